// File: rtl/pio_input_capture_slave_if.sv
// Avalon-MM bus bundle between the HPS-to-FPGA bridge and the PIO input capture slave.
// There is no waitrequest. Read data is registered and appears one cycle after avs_read.
interface pio_input_capture_slave_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_input_capture_slave.sv
// Debounced KEY/switch capture with sticky W1C event flags, a press counter and a level irq.
// Latency: pin to state is DEBOUNCE_CYCLES+2, read data is 1 cycle, irq is 1 cycle after its flag; no backpressure.
module pio_input_capture_slave #(
    parameter int N_BUTTONS       = 4,
    parameter int N_SWITCHES      = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    pio_input_capture_slave_if.slave  avs,
    input  logic [N_BUTTONS-1:0]      buttons_export,
    input  logic [N_SWITCHES-1:0]     switches_export,
    output logic                      irq
);
    localparam int N_IN = N_BUTTONS + N_SWITCHES;

    logic [N_IN-1:0]       sync1_q, sync2_q, deb_q, deb_d;
    logic [CNT_W-1:0]      cnt_q [N_IN];
    logic [CNT_W-1:0]      cnt_d [N_IN];
    logic [N_BUTTONS-1:0]  irq_mask_q, irq_mask_d, btn_edge_q, btn_edge_d, press_ev;
    logic [N_SWITCHES-1:0] sw_edge_q, sw_edge_d, sw_ev;
    logic                  sw_irq_en_q, sw_irq_en_d, irq_q, irq_d;
    logic [31:0]           press_cnt_q, press_cnt_d, cnt_base, press_pop;
    logic [31:0]           readdata_q, readdata_d, rd_data;
    logic                  unused_wdata;

    // Buttons are inverted as they enter the synchroniser, so a cleared flop means released.
    logic [N_IN-1:0] raw_in;
    assign raw_in = {switches_export, ~buttons_export};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_ev = deb_d[N_BUTTONS-1:0] & ~deb_q[N_BUTTONS-1:0];
    assign sw_ev    = deb_d[N_IN-1:N_BUTTONS] ^ deb_q[N_IN-1:N_BUTTONS];

    always_comb begin
        irq_mask_d  = irq_mask_q;
        sw_irq_en_d = sw_irq_en_q;
        btn_edge_d  = btn_edge_q;
        sw_edge_d   = sw_edge_q;
        cnt_base    = press_cnt_q;
        press_pop   = '0;
        rd_data     = '0;
        if (avs.avs_write) begin
            case (avs.avs_address)
                3'd2: begin
                    irq_mask_d  = avs.avs_writedata[N_BUTTONS-1:0];
                    sw_irq_en_d = avs.avs_writedata[16];
                end
                3'd3: btn_edge_d = btn_edge_q & ~avs.avs_writedata[N_BUTTONS-1:0];
                3'd4: sw_edge_d  = sw_edge_q & ~avs.avs_writedata[N_SWITCHES-1:0];
                3'd5: cnt_base   = '0;
                default: ;
            endcase
        end
        // New events are OR-ed in after the clear so a same-cycle set wins.
        btn_edge_d = btn_edge_d | press_ev;
        sw_edge_d  = sw_edge_d | sw_ev;
        for (int i = 0; i < N_BUTTONS; i++) begin
            press_pop = press_pop + 32'(press_ev[i]);
        end
        press_cnt_d = cnt_base + press_pop;

        case (avs.avs_address)
            3'd0: rd_data = 32'(deb_q[N_BUTTONS-1:0]);
            3'd1: rd_data = 32'(deb_q[N_IN-1:N_BUTTONS]);
            3'd2: rd_data = 32'(irq_mask_q) | (32'(sw_irq_en_q) << 16);
            3'd3: rd_data = 32'(btn_edge_q);
            3'd4: rd_data = 32'(sw_edge_q);
            3'd5: rd_data = press_cnt_q;
            default: rd_data = '0;
        endcase
        readdata_d = avs.avs_read ? rd_data : readdata_q;
        irq_d      = (|(btn_edge_q & irq_mask_q)) | (sw_irq_en_q & (|sw_edge_q));
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
            irq_mask_q  <= '0;
            sw_irq_en_q <= 1'b0;
            btn_edge_q  <= '0;
            sw_edge_q   <= '0;
            press_cnt_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= raw_in;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
            irq_mask_q  <= irq_mask_d;
            sw_irq_en_q <= sw_irq_en_d;
            btn_edge_q  <= btn_edge_d;
            sw_edge_q   <= sw_edge_d;
            press_cnt_q <= press_cnt_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;
    assign unused_wdata     = ^avs.avs_writedata;
endmodule

// File: tb/tb_pio_input_capture_slave.sv
// Directed bench for pio_input_capture_slave with a short debounce window (4 cycles).
module tb_pio_input_capture_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] buttons = 4'hF;
    logic [9:0] switches = '0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] rd;

    pio_input_capture_slave_if bus();

    pio_input_capture_slave #(
        .N_BUTTONS(4), .N_SWITCHES(10), .DEBOUNCE_CYCLES(4), .CNT_W(3)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .avs             (bus),
        .buttons_export  (buttons),
        .switches_export (switches),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.avs_readdata !== 32'h0) begin
            errors++; $display("FAIL reset_readdata got=%h exp=0", bus.avs_readdata);
        end
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++; $display("FAIL reset_addr%0d got=%h exp=0", a, rd);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_press;
        @(negedge clk);
        buttons = 4'b1101;
        bus.avs_address = 3'd0;
        bus.avs_read    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (bus.avs_readdata !== 32'h0) begin
                    errors++; $display("FAIL press_latency_early got=%h exp=0", bus.avs_readdata);
                end
            end
            if (k == 7) begin
                checks++;
                if (bus.avs_readdata !== 32'h2) begin
                    errors++; $display("FAIL press_latency_state got=%h exp=2", bus.avs_readdata);
                end
            end
        end
        bus.avs_read = 1'b0;
        repeat (13) @(negedge clk);
        buttons = 4'hF;
        repeat (10) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL press_edge got=%h exp=2", rd); end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL press_cnt got=%h exp=1", rd); end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL press_release_state got=%h exp=0", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked got=%b exp=0", irq); end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        buttons = 4'b1110;
        repeat (3) @(negedge clk);
        buttons = 4'hF;
        repeat (10) @(negedge clk);
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL glitch_state got=%h exp=0", rd); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL glitch_edge got=%h exp=2", rd); end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL glitch_cnt got=%h exp=1", rd); end
    endtask

    task automatic test_irq;
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL irq_mask_rb got=%h exp=1", rd); end
        @(negedge clk);
        buttons = 4'b1110;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
            end
            if (k == 7) begin
                checks++;
                if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
            end
        end
        bus_write(3'd3, 32'h1);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_clear got=%b exp=0", irq); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL irq_w1c_edge got=%h exp=2", rd); end
        buttons = 4'hF;
        repeat (10) @(negedge clk);
        // Press edge lands on the same clock edge as the W1C write.
        buttons = 4'b1110;
        repeat (5) @(negedge clk);
        bus.avs_address   = 3'd3;
        bus.avs_writedata = 32'h1;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL set_wins_edge got=%h exp=3", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL irq_cnt got=%h exp=3", rd); end
        buttons = 4'hF;
        repeat (10) @(negedge clk);
        bus_write(3'd3, 32'hF);
        bus_write(3'd2, 32'h0);
    endtask

    task automatic test_rw_same_cycle;
        @(negedge clk);
        bus.avs_address   = 3'd5;
        bus.avs_writedata = 32'h1234;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        checks++;
        if (bus.avs_readdata !== 32'h3) begin
            errors++; $display("FAIL rw_prewrite got=%h exp=3", bus.avs_readdata);
        end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rw_cnt_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_switch;
        @(negedge clk);
        switches = 10'h2A5;
        repeat (10) @(negedge clk);
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'h2A5) begin errors++; $display("FAIL sw_state got=%h exp=2a5", rd); end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h2A5) begin errors++; $display("FAIL sw_edge got=%h exp=2a5", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL sw_irq_masked got=%b exp=0", irq); end
        bus_write(3'd2, 32'h10000);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL sw_irq_rise got=%b exp=1", irq); end
        bus_write(3'd4, 32'h3FF);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL sw_irq_clear got=%b exp=0", irq); end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL sw_edge_clear got=%h exp=0", rd); end
        bus_write(3'd2, 32'h0);
    endtask

    task automatic test_back_to_back;
        bus_write(3'd3, 32'hF);
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cnt_write_zero got=%h exp=0", rd); end
        @(negedge clk);
        buttons = 4'b0011;
        repeat (10) @(negedge clk);
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL cnt_two_buttons got=%h exp=2", rd); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL edge_two_buttons got=%h exp=c", rd); end
        buttons = 4'hF;
        repeat (10) @(negedge clk);
        // Counter write lands on the same clock edge as a single press.
        buttons = 4'b1101;
        repeat (5) @(negedge clk);
        bus.avs_address   = 3'd5;
        bus.avs_writedata = 32'h0;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL cnt_write_with_press got=%h exp=1", rd); end
        buttons = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bus_write(3'd2, 32'h10001);
        @(negedge clk);
        buttons  = 4'b1110;
        switches = 10'h155;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        buttons  = 4'hF;
        switches = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++; $display("FAIL midreset_addr%0d got=%h exp=0", a, rd);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got=%b exp=0", irq); end
        // A button held through reset re-qualifies and counts exactly once.
        @(negedge clk);
        buttons = 4'b0111;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL held_reset_cnt got=%h exp=1", rd); end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL held_reset_state got=%h exp=8", rd); end
        buttons = 4'hF;
    endtask

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_rw_same_cycle();
        test_switch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
